cpu_mem_arbiter: RTL and testbench

- Shares one single-outstanding memory port between the fetch stage (inst) and the MEM stage (data).
- Sequences each transaction through an address phase and a data phase.
- Produces the stallreq_from_if and stallreq_from_mem requests that the pipeline hazard unit consumes.
- Handles a pipeline flush while a fetch is in flight by discarding that fetch's response.

---
 rtl/cpu_mem_arbiter_if.sv | 58 +++++
 rtl/cpu_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_if.sv
// Fetch/MEM/memory-port bundle of the shared memory arbiter.
// slave = arbiter side, master = pipeline plus memory side.
interface cpu_mem_arbiter_if;
  logic        flush;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        stallreq_from_if;
  logic        stallreq_from_mem;

  modport slave (
    input  flush,
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size,
    output mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output stallreq_from_if, stallreq_from_mem
  );

  modport master (
    output flush,
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size,
    input  mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  stallreq_from_if, stallreq_from_mem
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Single-outstanding arbiter between fetch and MEM stage
// onto one shared address/data-phase memory port.
module cpu_mem_arbiter #(
  parameter int DATA_STREAK_MAX = 2
) (
  input logic              clk,
  input logic              rst,
  cpu_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } state_t;

  localparam logic [2:0] SMAX = 3'(DATA_STREAK_MAX);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  streak_q;
  logic        discard_q;
  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;

  logic in_idle;
  logic in_addr;
  logic in_data;
  logic in_inst;
  logic grant_d;
  logic grant_i;
  logic done;
  logic done_i;
  logic done_d;
  logic drop;

  assign in_idle = state_q == IDLE;
  assign in_addr = state_q == I_ADDR
                 || state_q == D_ADDR;
  assign in_data = state_q == I_DATA
                 || state_q == D_DATA;
  assign in_inst = state_q == I_ADDR
                 || state_q == I_DATA;

  assign grant_d = !rst && in_idle
                 && bus.data_req
                 && (!bus.inst_req
                     || streak_q < SMAX);
  assign grant_i = !rst && in_idle
                 && !grant_d
                 && bus.inst_req;

  // Address phase may complete in the same beat as data.
  assign done = !rst
    && ((in_addr && bus.mem_addr_ok
         && bus.mem_data_ok)
        || (in_data && bus.mem_data_ok));
  assign done_i = done && in_inst;
  assign done_d = done && !in_inst;

  assign drop = discard_q || bus.flush;

  assign bus.inst_addr_ok = grant_i;
  assign bus.data_addr_ok = grant_d;
  assign bus.inst_data_ok = done_i && !drop;
  assign bus.data_data_ok = done_d;

  assign bus.inst_rdata = bus.inst_data_ok
                        ? bus.mem_rdata
                        : irdata_q;
  assign bus.data_rdata = bus.data_data_ok
                        ? bus.mem_rdata
                        : drdata_q;

  assign bus.mem_req   = in_addr;
  assign bus.mem_wr    = req_wr_q;
  assign bus.mem_size  = req_size_q;
  assign bus.mem_addr  = req_addr_q;
  assign bus.mem_wdata = req_wdata_q;

  assign bus.stallreq_from_if =
    bus.inst_req && !bus.inst_data_ok;
  assign bus.stallreq_from_mem =
    bus.data_req && !bus.data_data_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)
          state_d = D_ADDR;
        else if (grant_i)
          state_d = I_ADDR;
      end
      I_ADDR: begin
        if (done)
          state_d = IDLE;
        else if (bus.mem_addr_ok)
          state_d = I_DATA;
      end
      I_DATA: begin
        if (done)
          state_d = IDLE;
      end
      D_ADDR: begin
        if (done)
          state_d = IDLE;
        else if (bus.mem_addr_ok)
          state_d = D_DATA;
      end
      D_DATA: begin
        if (done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      discard_q   <= 1'b0;
      req_wr_q    <= 1'b0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        req_wr_q    <= bus.data_wr;
        req_size_q  <= bus.data_size;
        req_addr_q  <= bus.data_addr;
        req_wdata_q <= bus.data_wdata;
        if (bus.inst_req && streak_q < SMAX)
          streak_q <= streak_q + 3'd1;
      end
      if (grant_i) begin
        req_wr_q    <= 1'b0;
        req_size_q  <= 2'd2;
        req_addr_q  <= bus.inst_addr;
        req_wdata_q <= '0;
        streak_q    <= '0;
      end
      // The flushed fetch still drains on the port.
      if (done_i)
        discard_q <= 1'b0;
      else if (in_inst && bus.flush)
        discard_q <= 1'b1;
      if (bus.inst_data_ok)
        irdata_q <= bus.mem_rdata;
      if (bus.data_data_ok)
        drdata_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed cycle vectors for cpu_mem_arbiter plus a
// hand-written grant-order sequence for the streak limit.
module tb_cpu_mem_arbiter;
  localparam logic [31:0] B0 = 32'hBFC00000;
  localparam logic [31:0] B1 = 32'hBFC00380;
  localparam logic [31:0] DA = 32'h80000010;
  localparam logic [31:0] WD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if bus();

  cpu_mem_arbiter #(
    .DATA_STREAK_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ctl: rst flush ireq dreq dwr aok dok
  // ef:  iaok idok daok ddok mreq sif smem
  // em:  mwr msize (checked only when mreq)
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] ia;
    logic [31:0] rd;
    logic [6:0]  ef;
    logic [2:0]  em;
    logic [31:0] ma;
    logic [31:0] eir;
    logic [31:0] edr;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(
    logic [6:0]  c,
    logic [31:0] ia,
    logic [31:0] rd,
    logic [6:0]  ef,
    logic [2:0]  em,
    logic [31:0] ma,
    logic [31:0] eir,
    logic [31:0] edr
  );
    vec_t v;
    v.ctl = c;
    v.ia  = ia;
    v.rd  = rd;
    v.ef  = ef;
    v.em  = em;
    v.ma  = ma;
    v.eir = eir;
    v.edr = edr;
    return v;
  endfunction

  task automatic drive(
    input logic [6:0]  c,
    input logic [31:0] ia,
    input logic [31:0] rd
  );
    rst             = c[6];
    bus.flush       = c[5];
    bus.inst_req    = c[4];
    bus.data_req    = c[3];
    bus.data_wr     = c[2];
    bus.mem_addr_ok = c[1];
    bus.mem_data_ok = c[0];
    bus.inst_addr   = ia;
    bus.mem_rdata   = rd;
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {bus.inst_addr_ok,
            bus.inst_data_ok,
            bus.data_addr_ok,
            bus.data_data_ok,
            bus.mem_req,
            bus.stallreq_from_if,
            bus.stallreq_from_mem};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit isd[6] = '{1, 1, 0, 1, 1, 0};
    logic [31:0] ew;
    bus.data_size  = 2'd0;
    bus.data_addr  = DA;
    bus.data_wdata = WD;
    drive(7'b1000000, 0, 0);
    @(posedge clk); #1;

    // reset state
    tv.push_back(mk(7'b1000000, 0, 0,
      7'b0000000, 0, 0, 0, 0));
    // inst only
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b1000010, 0, 0, 0, 0));
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b0000110, 3'b010, B0, 0, 0));
    tv.push_back(mk(7'b0010010, B0, 0,
      7'b0000110, 3'b010, B0, 0, 0));
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b0000010, 0, 0, 0, 0));
    tv.push_back(mk(7'b0010001, B0, 32'h3C080001,
      7'b0100000, 0, 0, 32'h3C080001, 0));
    tv.push_back(mk(7'b0000000, B0, 0,
      7'b0000000, 0, 0, 32'h3C080001, 0));
    // inst and data together: store wins
    tv.push_back(mk(7'b0011100, B0, 0,
      7'b0010011, 0, 0, 32'h3C080001, 0));
    tv.push_back(mk(7'b0011110, B0, 0,
      7'b0000111, 3'b100, DA, 32'h3C080001, 0));
    tv.push_back(mk(7'b0011101, B0, 0,
      7'b0001010, 0, 0, 32'h3C080001, 0));
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b1000010, 0, 0, 32'h3C080001, 0));
    tv.push_back(mk(7'b0010011, B0, 32'h3C080002,
      7'b0100100, 3'b010, B0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0000000, B0, 0,
      7'b0000000, 0, 0, 32'h3C080002, 0));
    // flush after inst grant
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b1000010, 0, 0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0110000, B0, 0,
      7'b0000110, 3'b010, B0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0010010, B0, 0,
      7'b0000110, 3'b010, B0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0010001, B0, 32'hDEADDEAD,
      7'b0000010, 0, 0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0010000, B1, 0,
      7'b1000010, 0, 0, 32'h3C080002, 0));
    tv.push_back(mk(7'b0010010, B1, 0,
      7'b0000110, 3'b010, B1, 32'h3C080002, 0));
    tv.push_back(mk(7'b0010001, B1, 32'h24020001,
      7'b0100000, 0, 0, 32'h24020001, 0));
    tv.push_back(mk(7'b0000000, B1, 0,
      7'b0000000, 0, 0, 32'h24020001, 0));
    // load with addr_ok and data_ok together
    tv.push_back(mk(7'b0001000, B1, 0,
      7'b0010001, 0, 0, 32'h24020001, 0));
    tv.push_back(mk(7'b0001011, B1, 32'h12345678,
      7'b0001100, 3'b000, DA,
      32'h24020001, 32'h12345678));
    tv.push_back(mk(7'b0000001, B1, 0,
      7'b0000000, 0, 0,
      32'h24020001, 32'h12345678));
    // reset in I_DATA, then a stray data_ok
    tv.push_back(mk(7'b0010000, B0, 0,
      7'b1000010, 0, 0,
      32'h24020001, 32'h12345678));
    tv.push_back(mk(7'b0010010, B0, 0,
      7'b0000110, 3'b010, B0,
      32'h24020001, 32'h12345678));
    tv.push_back(mk(7'b1000000, B0, 0,
      7'b0000000, 0, 0,
      32'h24020001, 32'h12345678));
    tv.push_back(mk(7'b0000001, B0, 32'h55AA55AA,
      7'b0000000, 0, 0, 0, 0));

    foreach (tv[i]) begin
      drive(tv[i].ctl, tv[i].ia, tv[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d flags", i),
          32'(flags()), 32'(tv[i].ef));
      chk($sformatf("v%0d inst_rdata", i),
          bus.inst_rdata, tv[i].eir);
      chk($sformatf("v%0d data_rdata", i),
          bus.data_rdata, tv[i].edr);
      if (tv[i].ef[2]) begin
        ew = (tv[i].ma == DA) ? WD : 32'h0;
        chk($sformatf("v%0d wr_size", i),
            32'({bus.mem_wr, bus.mem_size}),
            32'(tv[i].em));
        chk($sformatf("v%0d mem_addr", i),
            bus.mem_addr, tv[i].ma);
        chk($sformatf("v%0d mem_wdata", i),
            bus.mem_wdata, ew);
      end
      @(posedge clk); #1;
    end

    // both requests held: expect D D I D D I
    for (int k = 0; k < 6; k++) begin
      drive(7'b0011100, B0, 0);
      @(negedge clk);
      chk($sformatf("grant%0d", k),
          32'({bus.data_addr_ok,
               bus.inst_addr_ok}),
          isd[k] ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      drive(7'b0011111, B0, 32'h1000 + k);
      @(negedge clk);
      chk($sformatf("grant%0d mem_wr", k),
          32'(bus.mem_wr), 32'(isd[k]));
      chk($sformatf("grant%0d size", k),
          32'(bus.mem_size),
          isd[k] ? 32'd0 : 32'd2);
      @(posedge clk); #1;
    end
    drive(7'b0000000, B0, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
